// File: rtl/clk_en_gen_pkg.sv
// Shared types and helpers for the clock-enable generator.
// Optional square-wave outputs are enabled with CLK_EN_GEN_SQ_OUT_EN.
package clk_en_gen_pkg;

  typedef enum logic [1:0] {
    ALIGN  = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // A write must name a real channel and keep the phase inside the period.
  function automatic logic cfg_legal(input int unsigned div,
                                     input int unsigned phase,
                                     input int unsigned ch,
                                     input int unsigned num_ch);
    return (div != 0) && (phase < div) && (ch < num_ch);
  endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One clock-enable channel: divide/phase registers, free-running counter, pulse decode.
// Square-wave decode is present only with CLK_EN_GEN_SQ_OUT_EN.
module clk_en_chan
  import clk_en_gen_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             align,
  input  logic             gate,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_ph,
`ifdef CLK_EN_GEN_SQ_OUT_EN
  output logic             sq,
`endif
  output logic             ce
);

  logic [CNT_W-1:0] div, ph, cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= CNT_W'(DEF_DIV);
      ph  <= '0;
    end else if (wr_en) begin
      div <= wr_div;
      ph  <= wr_ph;
    end
  end

  // >= rather than == so a counter left past a shrunken period still wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (align)                  cnt <= '0;
    else if (gate) begin
      if (cnt >= div - CNT_W'(1))    cnt <= '0;
      else                           cnt <= cnt + CNT_W'(1);
    end
  end

  assign ce = gate && (cnt == ph);

`ifdef CLK_EN_GEN_SQ_OUT_EN
  logic [CNT_W:0] diff, half;

  always_comb begin
    diff = '0;
    if (cnt >= ph) diff = {1'b0, cnt} - {1'b0, ph};
    else           diff = {1'b0, cnt} + {1'b0, div} - {1'b0, ph};
  end

  assign half = ({1'b0, div} + (CNT_W+1)'(1)) >> 1;
  assign sq   = gate && (div != CNT_W'(1)) && (diff < half);
`endif

endmodule

// File: rtl/clk_en_gen.sv
// Multi-channel clock-enable generator with align/settle/lock sequencing.
// Define CLK_EN_GEN_SQ_OUT_EN to add the sq_out square-wave outputs.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 4,
  localparam int CHW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] ce_out,
`ifdef CLK_EN_GEN_SQ_OUT_EN
  output logic [NUM_CH-1:0] sq_out,
`endif
  output logic              locked
);

  localparam int SW = $clog2(LOCK_CYCLES + 1);

  state_t          state, state_nxt;
  logic [SW-1:0]   settle_cnt;
  logic            align, gate, wr_acc, wr_legal;

  assign align     = (state == ALIGN);
  assign gate      = !align && run;
  assign cfg_ready = !align;
  assign locked    = (state == LOCKED);
  assign wr_acc    = cfg_valid && cfg_ready;
  assign wr_legal  = wr_acc && cfg_legal(32'(cfg_div), 32'(cfg_phase),
                                         32'(cfg_ch), 32'(NUM_CH));

  always_comb begin
    state_nxt = state;
    case (state)
      ALIGN:  if (run) state_nxt = SETTLE;
      SETTLE: begin
        if (!run || wr_legal)                          state_nxt = ALIGN;
        else if (settle_cnt == SW'(LOCK_CYCLES - 1))   state_nxt = LOCKED;
      end
      LOCKED: if (!run || wr_legal) state_nxt = ALIGN;
      default: state_nxt = ALIGN;
    endcase
  end

  // Settle count lives only inside SETTLE so a restart never inherits progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ALIGN;
      settle_cnt <= '0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      settle_cnt <= (state == SETTLE) ? settle_cnt + SW'(1) : '0;
      cfg_err    <= wr_acc && !wr_legal;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_en_chan #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .align  (align),
      .gate   (gate),
      .wr_en  (wr_legal && (cfg_ch == CHW'(i))),
      .wr_div (cfg_div),
      .wr_ph  (cfg_phase),
`ifdef CLK_EN_GEN_SQ_OUT_EN
      .sq     (sq_out[i]),
`endif
      .ce     (ce_out[i])
    );
  end

endmodule

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of clock-enable channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 8, width of divide/phase fields and per-channel counters.
REQ-003 SHALL have parameter LOCK_CYCLES, default 16, settle cycles before locked asserts (>=1).
REQ-004 SHALL have parameter DEF_DIV, default 4, per-channel reset divide value (1..2^CNT_W-1).
REQ-005 SHALL have port clk  in  1  sole clock; all logic is in this domain.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port run  in  1  global enable; 0 holds all channels idle.
REQ-008 SHALL have port cfg_valid  in  1  config write request.
REQ-009 SHALL have port cfg_ready  out  1  config write accepted when cfg_valid & cfg_ready.
REQ-010 SHALL have port cfg_ch  in  max(1,$clog2(NUM_CH))  target channel.
REQ-011 SHALL have port cfg_div  in  CNT_W  period N in cycles.
REQ-012 SHALL have port cfg_phase  in  CNT_W  enable offset P within the period.
REQ-013 SHALL have port cfg_err  out  1  one-cycle pulse, last write rejected.
REQ-014 SHALL have port ce_out  out  NUM_CH  per-channel one-cycle clock-enable pulses.
REQ-015 SHALL have port locked  out  1  all channels aligned and settled.

Function
REQ-016 SHALL keep per channel i registers div_i, ph_i, cnt_i; cnt_i counts 0..div_i-1, wrapping to 0.
REQ-017 SHALL run a state machine ALIGN -> SETTLE -> LOCKED.
REQ-018 ALIGN: lasts exactly one cycle; all cnt_i forced to 0; ce_out=0; cfg_ready=0; next state SETTLE if run=1, else stays ALIGN.
REQ-019 SETTLE: counters run; a settle counter counts LOCK_CYCLES cycles, then LOCKED; cfg_ready=1.
REQ-020 LOCKED: locked=1; cfg_ready=1; counters run.
REQ-021 SHALL drive ce_out[i]=1 combinationally when state is SETTLE or LOCKED, run=1 and cnt_i==ph_i. Period is div_i cycles; the first pulse falls ph_i cycles after ALIGN exits.
REQ-022 SHALL reject a write with cfg_div==0, cfg_phase>=cfg_div or cfg_ch>=NUM_CH: registers are unchanged, state is unchanged, and cfg_err pulses in the following cycle.
REQ-023 SHALL, on an accepted legal write, update div/ph of cfg_ch at the clock edge and enter ALIGN the next cycle; locked drops in that same cycle.
REQ-024 SHALL, when run=0 in any state, enter ALIGN the next cycle and hold all outputs idle (ce_out=0, locked=0).
REQ-025 On a legal write in the same cycle run falls, SHALL store the write and enter ALIGN.
REQ-026 SHALL accept back-to-back writes: each legal write restarts ALIGN/SETTLE; the settle count never carries over.

Reset
REQ-027 While rst_n=0, SHALL set state=ALIGN, cnt_i=0, div_i=DEF_DIV, ph_i=0, settle count=0, ce_out=0, locked=0, cfg_ready=0, cfg_err=0, sq_out=0.
REQ-028 Reset mid-operation SHALL discard all runtime config; release is synchronous to the next clk edge.

Configuration
REQ-029 Macro CLK_EN_GEN_SQ_OUT_EN, when defined, SHALL add output sq_out [NUM_CH]. sq_out[i] is high while ((cnt_i-ph_i) mod div_i) < ceil(div_i/2), under the same gating as ce_out, and 0 when div_i=1.
REQ-030 Without CLK_EN_GEN_SQ_OUT_EN, port sq_out and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 SHALL place the state enum (ALIGN, SETTLE, LOCKED) and the config-legality check function in package clk_en_gen_pkg.
REQ-032 SHALL implement one channel (counter, registers, ce/sq decode) as sub-module clk_en_chan, instantiated NUM_CH times via generate.

Verification
REQ-033 Reset, run=1, defaults: ALIGN 1 cycle, then ce_out[0] and ce_out[1] pulse together every 4 cycles; locked=1 exactly 16 cycles after SETTLE entry.
REQ-034 Write ch1 div=6 phase=2 while LOCKED: locked=0 the next cycle; ALIGN; ce_out[1] first at SETTLE cycle 2, then every 6 cycles; ch0 unchanged at period 4.
REQ-035 Write div=0, then div=5 phase=5: each gives a cfg_err pulse one cycle later; no state change; locked stays 1.
REQ-036 Drop run for 3 cycles while LOCKED: ce_out=0 and locked=0 from the next cycle; when run returns, ALIGN then SETTLE for 16 cycles, then relock.
REQ-037 Assert rst_n=0 mid-SETTLE after writing div=7: all outputs 0 immediately; after release, period reverts to 4.
REQ-038 With CLK_EN_GEN_SQ_OUT_EN, div=5 phase=1: sq_out high 3 cycles and low 2, with its rising edge coincident with ce_out.
